// File: rtl/hazard_fwd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl_pkg
//   Shared types for the hazard / forwarding controller:
//     - state_t    : controller FSM states
//     - fwd_sel_t  : EX operand source encodings driven onto the operand muxes
//     - shadow_t   : per-stage shadow entry {valid, rd, reg_write, is_load}
//   Register indices are carried at a fixed width (RD_W) inside the package so
//   the shadow struct can be shared; the top zero-extends its REG_AW-wide
//   indices into this width.
// -----------------------------------------------------------------------------
package hazard_fwd_ctrl_pkg;

    // Widest register index the shared shadow struct can carry.
    localparam int RD_W = 8;

    typedef logic [RD_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        FREEZE   = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     reg_write;
        logic     is_load;
    } shadow_t;

    localparam shadow_t SHADOW_EMPTY = '0;

    // True when the stage entry will write register src.
    function automatic logic writes_reg(input shadow_t entry, input reg_idx_t src);
        return entry.valid && entry.reg_write && (entry.rd == src);
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_match.sv
// -----------------------------------------------------------------------------
// fwd_match
//   Forwarding source select for one EX operand.
//   Ports:
//     src       in  ID source register index (zero-extended)
//     src_used  in  the instruction actually reads src
//     ex_entry  in  shadow entry of the instruction now in EX
//     mem_entry in  shadow entry of the instruction now in MEM
//     sel       out operand source: FWD_RF / FWD_EXMEM / FWD_MEMWB
//   The younger producer (EX) wins over the older one (MEM); x0 is hardwired
//   zero and is never forwarded.
// -----------------------------------------------------------------------------
module fwd_match
    import hazard_fwd_ctrl_pkg::*;
(
    input  reg_idx_t src,
    input  logic     src_used,
    input  shadow_t  ex_entry,
    input  shadow_t  mem_entry,
    output fwd_sel_t sel
);

    // NOTE: every combinational output gets a default first so no path
    // through the block can infer a latch.
    always_comb begin
        sel = FWD_RF;
        if (src_used && (src != '0)) begin
            if (writes_reg(ex_entry, src)) begin
                sel = FWD_EXMEM;
            end else if (writes_reg(mem_entry, src)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
//   Hazard detection and operand-forwarding control for a 5-stage pipeline.
//   Tracks shadow copies of the EX and MEM instructions, registers the EX
//   operand-mux selects at the ID->EX transition, inserts load-use bubbles,
//   handles branch flushes and whole-pipeline freezes on mem_busy, and flags
//   a freeze that lasts FREEZE_TIMEOUT cycles.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     id_valid                 ID holds a real instruction
//     id_rs1/id_rs2            ID source registers
//     id_rs1_used/id_rs2_used  source is actually read
//     id_rd, id_reg_write      ID destination and write enable
//     id_is_load, id_use_imm   ID is a load / operand B is the immediate
//     ex_flush                 taken branch/jump resolved in EX
//     mem_busy                 data memory not ready, freeze the pipeline
//     fwd_a_sel/fwd_b_sel      EX operand source (00 RF, 01 EX/MEM, 10 MEM/WB)
//     alu_b_sel                ALU operand B: 0 forwarded register, 1 immediate
//     stall                    hold PC and IF/ID
//     bubble                   load a NOP into ID/EX
//     err_timeout              sticky freeze-timeout flag
//   No datapath registers live here; the block only steers existing muxes.
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_AW         = 5,   // must not exceed RD_W
    parameter int FREEZE_TIMEOUT = 255  // must be at least 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              id_use_imm,
    input  logic              ex_flush,
    input  logic              mem_busy,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              alu_b_sel,
    output logic              stall,
    output logic              bubble,
    output logic              err_timeout
);

    localparam int               CNT_W   = $clog2(FREEZE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FREEZE_TIMEOUT);

    state_t           state, state_nxt, resume_state, eff_state;
    shadow_t          ex_q, mem_q, id_entry;
    reg_idx_t         rs1_x, rs2_x, rd_x;
    fwd_sel_t         sel_a, sel_b;
    fwd_sel_t         fwd_a_q, fwd_b_q;
    logic             alu_b_q;
    logic             lu_hazard, lu_stall_req, load_bubble;
    logic [CNT_W-1:0] frz_cnt, frz_cnt_nxt;
    logic             err_q;

    // Zero-extend the ID indices into the package index width.
    always_comb begin
        rs1_x = '0;
        rs2_x = '0;
        rd_x  = '0;
        rs1_x[REG_AW-1:0] = id_rs1;
        rs2_x[REG_AW-1:0] = id_rs2;
        rd_x[REG_AW-1:0]  = id_rd;
    end

    always_comb begin
        id_entry           = SHADOW_EMPTY;
        id_entry.valid     = id_valid;
        id_entry.rd        = rd_x;
        id_entry.reg_write = id_reg_write;
        id_entry.is_load   = id_is_load;
    end

    fwd_match u_fwd_a (
        .src       (rs1_x),
        .src_used  (id_rs1_used),
        .ex_entry  (ex_q),
        .mem_entry (mem_q),
        .sel       (sel_a)
    );

    fwd_match u_fwd_b (
        .src       (rs2_x),
        .src_used  (id_rs2_used),
        .ex_entry  (ex_q),
        .mem_entry (mem_q),
        .sel       (sel_b)
    );

    // A load in EX cannot forward its data yet: the consumer must wait a cycle.
    assign lu_hazard = id_valid && ex_q.valid && ex_q.is_load &&
                       ((id_rs1_used && (rs1_x != '0) && (rs1_x == ex_q.rd)) ||
                        (id_rs2_used && (rs2_x != '0) && (rs2_x == ex_q.rd)));

    // The first unfrozen cycle after a freeze behaves as the state that was
    // interrupted, so a pending load-use stall still completes.
    assign eff_state = (state == FREEZE) ? resume_state : state;

    // Flush wins over load-use: the dependent instruction is on the wrong path.
    assign lu_stall_req = (eff_state == RUN) && lu_hazard && !ex_flush;
    assign load_bubble  = ex_flush || lu_stall_req;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            resume_state <= RUN;
        end else begin
            state <= state_nxt;
            if (mem_busy && (state != FREEZE)) begin
                resume_state <= state;
            end
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_nxt = RUN;
        if (mem_busy) begin
            state_nxt = FREEZE;
        end else begin
            case (eff_state)
                RUN:     state_nxt = lu_stall_req ? LU_STALL : RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // rst overrides freeze, flush and any stall in progress.
    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        if (!rst) begin
            if (mem_busy) begin
                stall = 1'b1;
            end else if (ex_flush) begin
                bubble = 1'b1;
            end else if (lu_stall_req) begin
                stall  = 1'b1;
                bubble = 1'b1;
            end
        end
    end

    // ---------------- shadow pipeline, selects, freeze watchdog ----------------
    assign frz_cnt_nxt = (frz_cnt == CNT_MAX) ? frz_cnt : frz_cnt + CNT_W'(1);

    // NOTE: all control registers are reset; the shadow valid bits in
    // particular must start clear or stale entries would cause false forwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= SHADOW_EMPTY;
            mem_q   <= SHADOW_EMPTY;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
            alu_b_q <= 1'b0;
            frz_cnt <= '0;
            err_q   <= 1'b0;
        end else if (mem_busy) begin
            // Frozen: shadows and selects hold, only the watchdog moves.
            frz_cnt <= frz_cnt_nxt;
            if (frz_cnt_nxt == CNT_MAX) begin
                err_q <= 1'b1;
            end
        end else begin
            frz_cnt <= '0;
            mem_q   <= ex_q;
            if (load_bubble) begin
                ex_q    <= SHADOW_EMPTY;
                fwd_a_q <= FWD_RF;
                fwd_b_q <= FWD_RF;
                alu_b_q <= 1'b0;
            end else begin
                ex_q    <= id_entry;
                fwd_a_q <= sel_a;
                fwd_b_q <= sel_b;
                alu_b_q <= id_use_imm;
            end
        end
    end

    assign fwd_a_sel   = fwd_a_q;
    assign fwd_b_sel   = fwd_b_q;
    assign alu_b_sel   = alu_b_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
//   Directed bench for hazard_fwd_ctrl. Expected EX-cycle selects are queued
//   when an instruction is presented in ID and popped one edge later when the
//   instruction reaches EX; stall/bubble are checked mid-cycle.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

    localparam int REG_AW         = 5;
    localparam int FREEZE_TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              id_rs1_used, id_rs2_used;
    logic              id_reg_write, id_is_load, id_use_imm;
    logic              ex_flush, mem_busy;
    logic [1:0]        fwd_a_sel, fwd_b_sel;
    logic              alu_b_sel, stall, bubble, err_timeout;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(
        .REG_AW         (REG_AW),
        .FREEZE_TIMEOUT (FREEZE_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .id_use_imm   (id_use_imm),
        .ex_flush     (ex_flush),
        .mem_busy     (mem_busy),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .alu_b_sel    (alu_b_sel),
        .stall        (stall),
        .bubble       (bubble),
        .err_timeout  (err_timeout)
    );

    typedef struct {
        string      tag;
        logic [1:0] a;
        logic [1:0] b;
        logic       alu;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Queue the selects the instruction now in ID must show in its EX cycle.
    task automatic expect_ex(input string tag, input logic [1:0] a, input logic [1:0] b,
                             input logic alu);
        exp_t e;
        e.tag = tag;
        e.a   = a;
        e.b   = b;
        e.alu = alu;
        exp_q.push_back(e);
    endtask

    // Advance one edge, then compare any queued EX-cycle expectations.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.tag, "_fwd_a"}, 32'(fwd_a_sel), 32'(e.a));
            check({e.tag, "_alu_b"}, 32'(alu_b_sel), 32'(e.alu));
            // Operand B select is don't-care when the immediate is used.
            if (!e.alu) check({e.tag, "_fwd_b"}, 32'(fwd_b_sel), 32'(e.b));
        end
    endtask

    task automatic comb(input string tag, input logic st, input logic bb);
        #1;
        check({tag, "_stall"}, 32'(stall), 32'(st));
        check({tag, "_bubble"}, 32'(bubble), 32'(bb));
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic ld, input logic imm);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs1_used  = u1;
        id_rs2       = rs2;
        id_rs2_used  = u2;
        id_rd        = rd;
        id_reg_write = rw;
        id_is_load   = ld;
        id_use_imm   = imm;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        nop();
        cyc();
        cyc();
    endtask

    // Watchdog: the sequence is fixed-length, this only guards a broken clock.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset, with freeze/flush/hazard inputs active to test override ----
        rst      = 1'b1;
        mem_busy = 1'b1;
        ex_flush = 1'b1;
        set_id(1'b1, 5'd4, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1);
        cyc();
        cyc();
        comb("rst_hold", 1'b0, 1'b0);
        check("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
        check("rst_fwd_b", 32'(fwd_b_sel), 32'd0);
        check("rst_alu_b", 32'(alu_b_sel), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        rst      = 1'b0;
        mem_busy = 1'b0;
        ex_flush = 1'b0;
        nop();
        cyc();

        // ---- add x5,x1,x2 ; sub x6,x5,x3 -> EX/MEM forward on A ----
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        comb("add1", 1'b0, 1'b0);
        expect_ex("add1", 2'b00, 2'b00, 1'b0);
        cyc();
        set_id(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        comb("sub", 1'b0, 1'b0);
        expect_ex("sub", 2'b01, 2'b00, 1'b0);
        cyc();
        drain();

        // ---- add x5 ; nop ; or x7,x5,x5 -> MEM/WB forward on both ----
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        cyc();
        nop();
        cyc();
        set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        comb("or", 1'b0, 1'b0);
        expect_ex("or", 2'b10, 2'b10, 1'b0);
        cyc();
        drain();

        // ---- EX and MEM both write x5: youngest (01) wins ----
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        cyc();
        set_id(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        expect_ex("dbl_mid", 2'b01, 2'b00, 1'b0);
        cyc();
        set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        expect_ex("dbl", 2'b01, 2'b01, 1'b0);
        cyc();
        drain();

        // ---- lw x4 ; add x8,x4,x1 -> one-cycle load-use stall, then 10 ----
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1);
        expect_ex("lw", 2'b00, 2'b00, 1'b1);
        cyc();
        set_id(1'b1, 5'd4, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        comb("lu", 1'b1, 1'b1);
        cyc();
        comb("lu_done", 1'b0, 1'b0);
        expect_ex("lu_add", 2'b10, 2'b00, 1'b0);
        cyc();
        drain();

        // ---- load-use through rs2 ----
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1);
        cyc();
        set_id(1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        comb("lu_rs2", 1'b1, 1'b1);
        cyc();
        comb("lu_rs2_done", 1'b0, 1'b0);
        expect_ex("lu_rs2_add", 2'b00, 2'b10, 1'b0);
        cyc();
        drain();

        // ---- unused source matching a load in EX: no stall, select 00 ----
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1);
        cyc();
        set_id(1'b1, 5'd4, 1'b0, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        comb("unused", 1'b0, 1'b0);
        expect_ex("unused", 2'b00, 2'b00, 1'b0);
        cyc();
        drain();

        // ---- writes to x0 (incl. a load) then reads of x0 ----
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        cyc();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        cyc();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
        comb("x0", 1'b0, 1'b0);
        expect_ex("x0", 2'b00, 2'b00, 1'b0);
        cyc();
        drain();

        // ---- add x9 ; addi x9,x9,4 -> immediate on B, forward on A ----
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        cyc();
        set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
        expect_ex("addi", 2'b01, 2'b00, 1'b1);
        cyc();
        drain();

        // ---- flush coinciding with load-use: bubble without stall ----
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1);
        cyc();
        set_id(1'b1, 5'd4, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        ex_flush = 1'b1;
        comb("flush_lu", 1'b0, 1'b1);
        cyc();
        ex_flush = 1'b0;
        comb("after_flush", 1'b0, 1'b0);
        expect_ex("after_flush", 2'b10, 2'b00, 1'b0);
        cyc();
        drain();

        // ---- mem_busy for 3 cycles: selects frozen, then resume ----
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        cyc();
        set_id(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        expect_ex("pre_frz", 2'b01, 2'b00, 1'b0);
        cyc();
        set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            comb("frz", 1'b1, 1'b0);
            expect_ex("frz_hold", 2'b01, 2'b00, 1'b0);
            cyc();
        end
        mem_busy = 1'b0;
        comb("resume", 1'b0, 1'b0);
        expect_ex("resume_or", 2'b10, 2'b10, 1'b0);
        cyc();
        check("short_frz_err", 32'(err_timeout), 32'd0);
        drain();

        // ---- long freeze with flush held: timeout flag, sticky ----
        mem_busy = 1'b1;
        ex_flush = 1'b1;
        comb("long_frz", 1'b1, 1'b0);
        for (int i = 0; i < 254; i++) cyc();
        check("err_at_254", 32'(err_timeout), 32'd0);
        cyc();
        cyc();
        check("err_at_256", 32'(err_timeout), 32'd1);
        check("long_frz_stall", 32'(stall), 32'd1);
        mem_busy = 1'b0;
        comb("flush_after_frz", 1'b0, 1'b1);
        cyc();
        ex_flush = 1'b0;
        cyc();
        cyc();
        check("err_sticky", 32'(err_timeout), 32'd1);
        drain();

        // ---- reset in the middle of a load-use stall ----
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1);
        cyc();
        set_id(1'b1, 5'd4, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        comb("lu2", 1'b1, 1'b1);
        cyc();
        rst      = 1'b1;
        mem_busy = 1'b1;
        comb("rst_in_lu", 1'b0, 1'b0);
        cyc();
        check("rst_lu_fwd_a", 32'(fwd_a_sel), 32'd0);
        check("rst_lu_fwd_b", 32'(fwd_b_sel), 32'd0);
        check("rst_lu_alu_b", 32'(alu_b_sel), 32'd0);
        check("rst_lu_err", 32'(err_timeout), 32'd0);
        comb("rst_lu_out", 1'b0, 1'b0);
        rst      = 1'b0;
        mem_busy = 1'b0;
        comb("post_rst", 1'b0, 1'b0);
        expect_ex("post_rst", 2'b00, 2'b00, 1'b0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, is the register-index width.
REQ-002 Parameter FREEZE_TIMEOUT, default 255, is the number of consecutive frozen cycles that sets err_timeout.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset (the polarity and synchronicity are fixed):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2  in  REG_AW  ID source registers
- id_rs1_used, id_rs2_used  in  1  each source is actually read
- id_rd  in  REG_AW  ID destination
- id_reg_write  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- id_use_imm  in  1  ALU operand B takes the immediate
- ex_flush  in  1  branch/jump taken, resolved in EX
- mem_busy  in  1  data memory not ready; freeze the whole pipeline
- fwd_a_sel, fwd_b_sel  out  2  EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB
- alu_b_sel  out  1  select for the ALU operand-B mux: 0 forwarded register, 1 immediate
- stall  out  1  hold PC and IF/ID
- bubble  out  1  load a NOP into ID/EX
- err_timeout  out  1  sticky freeze-timeout flag

Function
REQ-004 The block SHALL keep shadow entries {valid, rd, reg_write, is_load} for the EX and MEM stages, advanced each unfrozen cycle (ID->EX, EX->MEM).
REQ-005 fwd_a_sel, fwd_b_sel and alu_b_sel SHALL be registered at the ID->EX transition, so they are valid throughout the instruction's EX cycle.
REQ-006 Forward detection for each source SHALL follow these rules, in order:
- if the source is used, its register is nonzero, and the EX entry is valid with reg_write and rd equal to the source, select 01;
- else if the same holds for the MEM entry, select 10;
- else select 00.
REQ-007 Register x0 SHALL never be forwarded; an unused source SHALL select 00.
REQ-008 alu_b_sel SHALL equal id_use_imm captured with the instruction; fwd_b_sel is still computed and is don't-care when alu_b_sel=1.
REQ-009 The FSM states SHALL be RUN, LU_STALL and FREEZE.
REQ-010 Load-use: in RUN, if id_valid and the EX entry is a valid load with rd equal to a used nonzero ID source, then stall=1 and bubble=1 for exactly one cycle, and the state moves to LU_STALL.
REQ-011 LU_STALL SHALL return to RUN on the next unfrozen cycle; the re-evaluated ID instruction then selects 10 for that source.
REQ-012 When mem_busy=1, from any state, the state SHALL be FREEZE with stall=1 and bubble=0; shadow entries and registered selects SHALL hold.
REQ-013 On mem_busy deassertion the FSM SHALL return to RUN, or to LU_STALL if a load-use stall was pending.
REQ-014 ex_flush=1 while unfrozen SHALL load a bubble into the EX shadow entry and force bubble=1.
REQ-015 Simultaneous ex_flush and load-use SHALL resolve in favour of flush: no stall, state RUN.
REQ-016 ex_flush SHALL be ignored while mem_busy=1; the driver holds ex_flush until the freeze ends.
REQ-017 A freeze counter SHALL increment each FREEZE cycle, saturate, and clear on leaving FREEZE.
REQ-018 When the counter reaches FREEZE_TIMEOUT, err_timeout SHALL set and remain set until reset.
REQ-019 id_valid=0 SHALL produce no stall and SHALL shift an invalid entry into EX.

Reset
REQ-020 Under rst the block SHALL enter RUN, clear all shadow valid bits, clear the counter, and drive fwd_a_sel=fwd_b_sel=00, alu_b_sel=0, stall=0, bubble=0, err_timeout=0 on the following edge.
REQ-021 rst SHALL override mem_busy, ex_flush and any in-progress stall.

Structure
REQ-022 The shared package SHALL hold the FSM state enum, the fwd_sel encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB) and the shadow-entry struct.
REQ-023 A sub-module fwd_match SHALL compute one operand's 2-bit select and be instantiated twice.
REQ-024 The block SHALL contain no datapath registers; it drives the existing operand muxes only.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- add x5,x1,x2 then sub x6,x5,x3: fwd_a_sel=01 in the sub's EX cycle, no stall.
- add x5; nop; or x7,x5,x5: fwd_a_sel=fwd_b_sel=10.
- Both EX and MEM write x5 and the next instruction reads x5: 01 is chosen.
- lw x4 then add x8,x4,x1: stall=1 and bubble=1 for 1 cycle, then fwd_a_sel=10.
- Writes to x0 followed by reads of x0: selects stay 00.
- Other cases:
  - addi x9,x9,4: alu_b_sel=1.
  - ex_flush coinciding with a load-use hazard: bubble=1, stall=0.
  - mem_busy held 3 cycles: stall=1, selects frozen, then resumes.
  - mem_busy held 256 cycles: err_timeout=1 and sticky.
  - rst mid-LU_STALL: all outputs 0 next cycle.
